// File: rtl/fp_mul_stream_top_if.sv
// Operand/result handshake bundle for the streaming floating-point multiplier.
interface fp_mul_stream_top_if #(
  parameter int unsigned W = 32
);
  logic         inReady;
  logic [W-1:0] inBus;
  logic         inAccept;
  logic         resultReady;
  logic         resultAccept;
  logic [W-1:0] outBus;

  modport master (
    output inReady, inBus, resultAccept,
    input  inAccept, resultReady, outBus
  );

  modport slave (
    input  inReady, inBus, resultAccept,
    output inAccept, resultReady, outBus
  );
endinterface

// File: rtl/fp_mul_stream_top.sv
// Streaming FP multiplier: A then B over one bus, shift-add mantissa product,
// normalise/round, results queued in a small FIFO behind a ready/accept port.
module fp_mul_stream_top #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 23,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned RND_MODE  = 1
) (
  input logic               clk,
  input logic               rst,
  fp_mul_stream_top_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned M  = MAN_W + 1;
  localparam int unsigned PW = 2 * M;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = $clog2(M + 1);

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic [W-1:0]         QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE_A, WAIT_B, MUL, NORM, PACK} state_t;

  state_t                r_state;
  logic                  r_in_accept;
  logic [W-1:0]          r_a;
  logic                  r_sign;
  logic signed [EW-1:0]  r_exp;
  logic [PW-1:0]         r_mcand;
  logic [M-1:0]          r_mplier;
  logic [PW-1:0]         r_acc;
  logic [NW-1:0]         r_cnt;
  logic [W-1:0]          r_res;
  logic [W-1:0]          r_fifo [OUT_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_in_xfer;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;
  logic [EXP_W-1:0]      w_a_exp, w_b_exp;
  logic [MAN_W-1:0]      w_a_frac, w_b_frac;
  logic                  w_sign;
  logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic                  w_spec;
  logic [W-1:0]          w_spec_res;
  logic signed [EW-1:0]  w_exp_sum;
  logic [PW-2:0]         w_pn;
  logic [MAN_W-1:0]      w_frac;
  logic                  w_guard, w_sticky, w_round_up;
  logic [MAN_W:0]        w_frac_r;
  logic signed [EW-1:0]  w_exp_n;
  logic [W-1:0]          w_norm_res;

  assign w_in_xfer = bus.inReady & r_in_accept;
  assign w_pop     = bus.resultAccept & (r_count != '0);
  assign w_full    = (r_count == CW'(OUT_DEPTH));
  assign w_push    = (r_state == PACK) & (~w_full | w_pop);

  assign w_a_exp  = r_a[W-2 -: EXP_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_exp  = bus.inBus[W-2 -: EXP_W];
  assign w_b_frac = bus.inBus[MAN_W-1:0];
  assign w_sign   = r_a[W-1] ^ bus.inBus[W-1];
  assign w_a_nan  = (w_a_exp == '1) & (w_a_frac != '0);
  assign w_b_nan  = (w_b_exp == '1) & (w_b_frac != '0);
  assign w_a_inf  = (w_a_exp == '1) & (w_a_frac == '0);
  assign w_b_inf  = (w_b_exp == '1) & (w_b_frac == '0);
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS;

  // Special-value classification of the operand pair, resolved on the B edge.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
      w_spec_res = QNAN;
    end else if (w_a_inf | w_b_inf) begin
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero | w_b_zero) begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Normalise the product to a leading one, then round and range-check the exponent.
  always_comb begin
    w_pn       = r_acc[PW-1] ? r_acc[PW-2:0] : {r_acc[PW-3:0], 1'b0};
    w_frac     = w_pn[PW-2 -: MAN_W];
    w_guard    = w_pn[PW-2-MAN_W];
    w_sticky   = |w_pn[PW-3-MAN_W:0];
    w_round_up = (RND_MODE == 1) & w_guard & (w_sticky | w_frac[0]);
    w_frac_r   = {1'b0, w_frac} + (MAN_W+1)'(w_round_up);
    w_exp_n    = r_exp + $signed(EW'(r_acc[PW-1])) + $signed(EW'(w_frac_r[MAN_W]));
    if (w_exp_n >= EMAX) begin
      w_norm_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_exp_n <= EZERO) begin
      w_norm_res = {r_sign, {(W-1){1'b0}}};
    end else begin
      w_norm_res = {r_sign, w_exp_n[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
    end
  end

  // Operation sequencer: capture A, capture B, iterate, normalise, hand off to FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE_A;
      r_in_accept <= 1'b1;
      r_a         <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
    end else begin
      case (r_state)
        IDLE_A: begin
          if (w_in_xfer) begin
            r_a     <= bus.inBus;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_in_xfer) begin
            r_sign      <= w_sign;
            r_exp       <= w_exp_sum;
            r_in_accept <= 1'b0;
            if (w_spec) begin
              r_res   <= w_spec_res;
              r_state <= PACK;
            end else begin
              r_acc    <= '0;
              r_mcand  <= PW'({1'b1, w_a_frac});
              r_mplier <= {1'b1, w_b_frac};
              r_cnt    <= '0;
              r_state  <= MUL;
            end
          end
        end
        MUL: begin
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + NW'(1);
          if (r_cnt == NW'(M - 1)) r_state <= NORM;
        end
        NORM: begin
          r_res   <= w_norm_res;
          r_state <= PACK;
        end
        PACK: begin
          if (w_push) begin
            r_state     <= IDLE_A;
            r_in_accept <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE_A;
          r_in_accept <= 1'b1;
        end
      endcase
    end
  end

  // Result FIFO; a pop frees the slot for a push on the same edge when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) r_fifo[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= r_res;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.inAccept    = r_in_accept;
  assign bus.resultReady = (r_count != '0);
  assign bus.outBus      = r_fifo[r_rptr];
endmodule

// File: tb/tb_fp_mul_stream_top.sv
// Bench for fp_mul_stream_top: directed corner cases plus random operands
// against an arithmetic reference model, on a default instance and a
// two-entry truncating instance.
module tb_fp_mul_stream_top;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  fp_mul_stream_top_if #(.W(32)) if0 ();
  fp_mul_stream_top_if #(.W(32)) if1 ();

  fp_mul_stream_top #(.EXP_W(8), .MAN_W(23), .OUT_DEPTH(4), .RND_MODE(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  fp_mul_stream_top #(.EXP_W(8), .MAN_W(23), .OUT_DEPTH(2), .RND_MODE(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: IEEE-style multiply at default widths, flush-to-zero, no subnormals.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input int rnd);
    logic s = a[31] ^ b[31];
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    bit a_nan = (ea == 255) && (a[22:0] != 0);
    bit b_nan = (eb == 255) && (b[22:0] != 0);
    bit a_inf = (ea == 255) && (a[22:0] == 0);
    bit b_inf = (eb == 255) && (b[22:0] == 0);
    bit a_zero = (ea == 0);
    bit b_zero = (eb == 0);
    longint unsigned p, mant, rem;
    int e;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) e = e + 1;
    else p = p << 1;
    mant = p >> 24;
    rem  = p % (64'd1 << 24);
    if (rnd == 1 && (rem > 64'h800000 || (rem == 64'h800000 && mant % 2 == 1))) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(mant)};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    bit an = (a[30:23] != 8'h00) && (a[30:23] != 8'hFF);
    bit bn = (b[30:23] != 8'h00) && (b[30:23] != 8'hFF);
    return (an && bn) ? 26 : 1;
  endfunction

  function automatic logic [31:0] rnd_op();
    int k = $urandom_range(0, 19);
    logic [7:0] e;
    logic [22:0] f = 23'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 1) f = '0;
    end
    else if (k < 5) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(64, 190));
    return {1'($urandom), e, f};
  endfunction

  task automatic set_in(input int s, input logic rdy, input logic [31:0] w);
    if (s == 0) begin if0.inReady = rdy; if0.inBus = w; end
    else begin if1.inReady = rdy; if1.inBus = w; end
  endtask

  task automatic set_pop(input int s, input logic v);
    if (s == 0) if0.resultAccept = v;
    else if1.resultAccept = v;
  endtask

  function automatic logic get_acc(input int s);
    return (s == 0) ? if0.inAccept : if1.inAccept;
  endfunction

  function automatic logic get_rr(input int s);
    return (s == 0) ? if0.resultReady : if1.resultReady;
  endfunction

  function automatic logic [31:0] get_out(input int s);
    return (s == 0) ? if0.outBus : if1.outBus;
  endfunction

  task automatic send(input int s, input logic [31:0] w);
    int n = 0;
    set_in(s, 1'b1, w);
    while (!get_acc(s) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("send_accept", 32'(get_acc(s)), 32'd1);
    @(posedge clk); #1;
    set_in(s, 1'b0, 32'h0);
  endtask

  task automatic wait_rr(input int s, output int n);
    n = 0;
    while (!get_rr(s) && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic pop_chk(input int s, input string tag, input logic [31:0] exp);
    int n;
    wait_rr(s, n);
    check(tag, get_out(s), exp);
    set_pop(s, 1'b1);
    @(posedge clk); #1;
    set_pop(s, 1'b0);
  endtask

  task automatic op(input int s, input logic [31:0] a, input logic [31:0] b,
                    input string tag, input logic [31:0] exp, input int lat);
    int n;
    send(s, a);
    send(s, b);
    wait_rr(s, n);
    if (lat >= 0) check({tag, "_lat"}, 32'(n), 32'(lat));
    pop_chk(s, tag, exp);
  endtask

  logic [31:0] da [3];
  logic [31:0] db [3];
  logic [31:0] dr [3];

  initial begin
    int n;
    n_cmp = 0;
    n_mis = 0;
    clk = 1'b0;
    rst = 1'b1;
    set_in(0, 1'b0, 32'h0); set_in(1, 1'b0, 32'h0);
    set_pop(0, 1'b0); set_pop(1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check("rst_acc", 32'(get_acc(s)), 32'd1);
      check("rst_rr",  32'(get_rr(s)),  32'd0);
      check("rst_out", get_out(s),      32'h0);
    end

    op(0, 32'h40000000, 32'h40400000, "two_x_three", 32'h40C00000, 26);
    op(0, 32'h3F800001, 32'h3FC00000, "tie_rne",     32'h3FC00002, 26);
    op(1, 32'h3F800001, 32'h3FC00000, "tie_trunc",   32'h3FC00001, 26);
    op(0, 32'h7F800000, 32'h00000000, "inf_x_zero",  32'h7FC00000, 1);
    op(0, 32'h7F000000, 32'h7F000000, "overflow",    32'h7F800000, 26);
    op(0, 32'h00800000, 32'h00800000, "underflow",   32'h00000000, 26);
    op(0, 32'hFF800000, 32'h40000000, "neg_inf",     32'hFF800000, 1);
    op(0, 32'h80000000, 32'h3F800000, "neg_zero",    32'h80000000, 1);
    op(0, 32'h7FA00000, 32'h3F800000, "nan_in",      32'h7FC00000, 1);

    // Two-entry FIFO with no consumer: third result must stall in PACK.
    for (int i = 0; i < 3; i++) begin
      da[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      db[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      dr[i] = ref_mul(da[i], db[i], 0);
      send(1, da[i]);
      send(1, db[i]);
    end
    repeat (40) @(posedge clk);
    #1;
    check("d2_hold_acc", 32'(get_acc(1)), 32'd0);
    check("d2_full_rr",  32'(get_rr(1)),  32'd1);
    check("d2_head0",    get_out(1),      dr[0]);
    set_pop(1, 1'b1);
    @(posedge clk); #1;
    set_pop(1, 1'b0);
    check("d2_push_on_pop_acc", 32'(get_acc(1)), 32'd1);
    pop_chk(1, "d2_head1", dr[1]);
    pop_chk(1, "d2_head2", dr[2]);
    check("d2_empty_rr", 32'(get_rr(1)), 32'd0);

    // Reset in the middle of MUL with one result parked in the FIFO.
    send(0, 32'h40000000);
    send(0, 32'h40400000);
    wait_rr(0, n);
    check("mid_pre_rr", 32'(get_rr(0)), 32'd1);
    send(0, 32'h40A00000);
    send(0, 32'h40E00000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_rr",  32'(get_rr(0)),  32'd0);
    check("mid_rst_acc", 32'(get_acc(0)), 32'd1);
    check("mid_rst_out", get_out(0),      32'h0);
    op(0, 32'h40000000, 32'h40400000, "after_rst", 32'h40C00000, 26);

    // Random operands on both instances.
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a, b;
      int s;
      a = rnd_op();
      b = rnd_op();
      s = i % 2;
      op(s, a, b, $sformatf("rnd%0d_u%0d", i, s), ref_mul(a, b, (s == 0) ? 1 : 0), ref_lat(a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
